// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encoding for the UART memory bridge.
// Command/response byte values used on the wire.
package uart_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_MEM,
        S_RESP
    } state_t;

endpackage

// File: rtl/uart_byte_port.sv
// Byte-level handshakes towards the UART engine.
// Turns rx_clear and start_tx/tx_done into one-cycle strobes.
module uart_byte_port (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_available,
    input  logic [7:0] rx_value,
    input  logic       rx_en,
    output logic       rx_clear,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    input  logic       byte_send,
    input  logic [7:0] send_data,
    output logic       send_done,
    output logic       start_tx,
    output logic [7:0] tx_value,
    input  logic       tx_done
);

    logic       rx_clear_q, rx_clear_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       start_tx_q, start_tx_d;
    logic [7:0] tx_value_q, tx_value_d;
    logic       pend_q, pend_d;
    logic [7:0] pdata_q, pdata_d;
    logic       send_done_q, send_done_d;

    // Next-state for receive acknowledge and transmit request
    always_comb begin
        rx_clear_d   = rx_clear_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        if (rx_clear_q) begin
            if (!rx_available) rx_clear_d = 1'b0;
        end else if (rx_en && rx_available) begin
            rx_clear_d   = 1'b1;
            byte_valid_d = 1'b1;
            byte_data_d  = rx_value;
        end

        start_tx_d  = start_tx_q;
        tx_value_d  = tx_value_q;
        pend_d      = pend_q;
        pdata_d     = pdata_q;
        send_done_d = 1'b0;
        if (byte_send) begin
            pend_d  = 1'b1;
            pdata_d = send_data;
        end
        if (start_tx_q) begin
            if (tx_done) begin
                start_tx_d  = 1'b0;
                send_done_d = 1'b1;
            end
        end else if (pend_q && !tx_done) begin
            start_tx_d = 1'b1;
            tx_value_d = pdata_q;
            pend_d     = 1'b0;
        end
    end

    // Handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_clear_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            start_tx_q   <= 1'b0;
            tx_value_q   <= 8'h00;
            pend_q       <= 1'b0;
            pdata_q      <= 8'h00;
            send_done_q  <= 1'b0;
        end else begin
            rx_clear_q   <= rx_clear_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            start_tx_q   <= start_tx_d;
            tx_value_q   <= tx_value_d;
            pend_q       <= pend_d;
            pdata_q      <= pdata_d;
            send_done_q  <= send_done_d;
        end
    end

    assign rx_clear   = rx_clear_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign start_tx   = start_tx_q;
    assign tx_value   = tx_value_q;
    assign send_done  = send_done_q;

endmodule

// File: rtl/uart_mem_bridge.sv
// UART command responder driving a request/ready memory port.
// Optional inter-byte timeout: define UART_BRIDGE_TIMEOUT_EN.
module uart_mem_bridge
    import uart_bridge_pkg::*;
#(
    parameter int ADDR_BYTES = 2
`ifdef UART_BRIDGE_TIMEOUT_EN
    , parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_available,
    input  logic [7:0]              rx_value,
    output logic                    rx_clear,
    output logic                    start_tx,
    output logic [7:0]              tx_value,
    input  logic                    tx_done,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [8*ADDR_BYTES-1:0] mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_ready,
    output logic                    busy
);

    localparam int AW = 8 * ADDR_BYTES;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic            send_q, send_d;
    logic [7:0]      sdata_q, sdata_d;
    logic            inflight_q, inflight_d;
    logic            busy_q, busy_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [23:0]     tmo_q, tmo_d;
`endif

    logic            rx_en;
    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            send_done;

    assign rx_en = (state_q == S_CMD) || (state_q == S_ADDR) ||
                   (state_q == S_WDATA);

    uart_byte_port u_port (
        .clk          (clk),
        .rst          (rst),
        .rx_available (rx_available),
        .rx_value     (rx_value),
        .rx_en        (rx_en),
        .rx_clear     (rx_clear),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_send    (send_q),
        .send_data    (sdata_q),
        .send_done    (send_done),
        .start_tx     (start_tx),
        .tx_value     (tx_value),
        .tx_done      (tx_done)
    );

    // Frame decoder, memory access and response sequencing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        send_d     = 1'b0;
        sdata_d    = sdata_q;
        inflight_d = inflight_q;
`ifdef UART_BRIDGE_TIMEOUT_EN
        tmo_d      = 24'd0;
`endif
        unique case (state_q)
            S_CMD: begin
                if (byte_valid) begin
                    cmd_d = byte_data;
                    cnt_d = 3'd0;
                    if (byte_data == CMD_WRITE || byte_data == CMD_READ) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d    = S_RESP;
                        inflight_d = 1'b0;
                    end
                end
            end
            S_ADDR: begin
                if (byte_valid) begin
                    addr_d = (addr_q << 8) | AW'(byte_data);
                    if (cnt_q == 3'(ADDR_BYTES - 1)) begin
                        cnt_d = 3'd0;
                        if (cmd_q == CMD_WRITE) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d   = S_MEM;
                            mem_req_d = 1'b1;
                            mem_we_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_WDATA: begin
                if (byte_valid) begin
                    wdata_d = {wdata_q[23:0], byte_data};
                    if (cnt_q == 3'd3) begin
                        cnt_d     = 3'd0;
                        state_d   = S_MEM;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if (cmd_q == CMD_READ) rdata_d = mem_rdata;
                    state_d    = S_RESP;
                    cnt_d      = 3'd0;
                    inflight_d = 1'b0;
                end
            end
            S_RESP: begin
                if (!inflight_q) begin
                    send_d     = 1'b1;
                    inflight_d = 1'b1;
                    if (cmd_q == CMD_READ)       sdata_d = rdata_q[31:24];
                    else if (cmd_q == CMD_WRITE) sdata_d = RSP_OK;
                    else                         sdata_d = RSP_ERR;
                end else if (send_done) begin
                    inflight_d = 1'b0;
                    rdata_d    = rdata_q << 8;
                    if (cmd_q != CMD_READ || cnt_q == 3'd3) begin
                        state_d = S_CMD;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_CMD;
        endcase
`ifdef UART_BRIDGE_TIMEOUT_EN
        if (state_q == S_ADDR || state_q == S_WDATA) begin
            if (byte_valid) begin
                tmo_d = 24'd0;
            end else if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
                state_d = S_CMD;
                cnt_d   = 3'd0;
            end else begin
                tmo_d = tmo_q + 24'd1;
            end
        end
`endif
        busy_d = (state_d != S_CMD);
    end

    // Bridge state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CMD;
            cnt_q      <= 3'd0;
            cmd_q      <= 8'h00;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            send_q     <= 1'b0;
            sdata_q    <= 8'h00;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
            tmo_q      <= 24'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            send_q     <= send_d;
            sdata_q    <= sdata_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

endmodule
